// File: rtl/sap_sequencer.sv
// SAP control sequencer: PC, microstep counter, halt/resume, conditional jumps.
// Define SAP_SEQ_STACK_EN to build the call/return stack and the sticky FAULT state.
module sap_sequencer #(
  parameter int PC_WIDTH    = 4,
  parameter int STEPS       = 8,
  parameter int STACK_DEPTH = 4,
  localparam int STEP_WIDTH  = $clog2(STEPS),
  localparam int LEVEL_WIDTH = $clog2(STACK_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   i_counter_enable,
  input  logic                   i_jump,
  input  logic [1:0]             i_jump_cond,
  input  logic                   i_zero,
  input  logic                   i_carry,
  input  logic                   i_odd,
  input  logic                   i_call,
  input  logic                   i_ret,
  input  logic [PC_WIDTH-1:0]    i_load_data,
  input  logic                   i_adv,
  input  logic                   i_halt,
  input  logic                   i_resume,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [STEP_WIDTH-1:0]  o_step,
  output logic                   o_halted,
  output logic                   o_fault,
  output logic [LEVEL_WIDTH-1:0] o_stack_level
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(STEPS - 1);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  halted_q, halted_d;
  logic                  cond_ok_s;
  logic                  step_adv_s;

`ifdef SAP_SEQ_STACK_EN
  localparam int IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(STACK_DEPTH);

  logic                   fault_q, fault_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [PC_WIDTH-1:0]    stack_q [STACK_DEPTH];
  logic                   push_s;
  logic [IDX_WIDTH-1:0]   push_idx_s;
  logic [IDX_WIDTH-1:0]   top_idx_s;
  logic [PC_WIDTH-1:0]    push_data_s;

  assign push_idx_s = IDX_WIDTH'(level_q);
  assign top_idx_s  = IDX_WIDTH'(level_q - LEVEL_WIDTH'(1));
`else
  logic unused_ret_s;
  assign unused_ret_s = i_ret;
`endif

  always_comb begin
    case (i_jump_cond)
      2'd0:    cond_ok_s = 1'b1;
      2'd1:    cond_ok_s = i_zero;
      2'd2:    cond_ok_s = i_carry;
      2'd3:    cond_ok_s = i_odd;
      default: cond_ok_s = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    step_d     = step_q;
    halted_d   = halted_q;
    step_adv_s = 1'b0;
`ifdef SAP_SEQ_STACK_EN
    fault_d     = fault_q;
    level_d     = level_q;
    push_s      = 1'b0;
    push_data_s = pc_q + PC_WIDTH'(1);
`endif
    if (clk_en) begin
      case (state_q)
        ST_RUN: begin
          step_adv_s = 1'b1;
          if (i_halt) begin
            state_d    = ST_HALTED;
            halted_d   = 1'b1;
            step_adv_s = 1'b0;
          end
`ifdef SAP_SEQ_STACK_EN
          else if (i_ret) begin
            if (level_q == LEVEL_WIDTH'(0)) begin
              state_d    = ST_FAULT;
              fault_d    = 1'b1;
              step_adv_s = 1'b0;
            end else begin
              pc_d    = stack_q[top_idx_s];
              level_d = level_q - LEVEL_WIDTH'(1);
            end
          end else if (i_call) begin
            // Overflow faults without touching the stack or PC.
            if (level_q == FULL_LEVEL) begin
              state_d    = ST_FAULT;
              fault_d    = 1'b1;
              step_adv_s = 1'b0;
            end else begin
              push_s  = 1'b1;
              pc_d    = i_load_data;
              level_d = level_q + LEVEL_WIDTH'(1);
            end
          end
`else
          else if (i_call) begin
            pc_d = i_load_data;
          end
`endif
          else if (i_jump && cond_ok_s) begin
            pc_d = i_load_data;
          end else if (i_counter_enable) begin
            pc_d = pc_q + PC_WIDTH'(1);
          end else begin
            pc_d = pc_q;
          end

          if (step_adv_s) begin
            step_d = (i_adv || (step_q == LAST_STEP)) ? '0 : step_q + STEP_WIDTH'(1);
          end else begin
            step_d = step_q;
          end
        end
        ST_HALTED: begin
          if (i_resume) begin
            state_d  = ST_RUN;
            halted_d = 1'b0;
            step_d   = '0;
          end else begin
            state_d = ST_HALTED;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          // Illegal encoding: park in HALTED so software must explicitly resume.
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= '0;
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

`ifdef SAP_SEQ_STACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
      level_q <= '0;
    end else begin
      fault_q <= fault_d;
      level_q <= level_d;
    end
  end

  // Stack contents need no reset: only entries below level_q are ever read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_q[push_idx_s] <= push_data_s;
    end
  end

  assign o_fault       = fault_q;
  assign o_stack_level = level_q;
`else
  assign o_fault       = 1'b0;
  assign o_stack_level = '0;
`endif

  assign o_pc     = pc_q;
  assign o_step   = step_q;
  assign o_halted = halted_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Randomised self-checking bench for sap_sequencer against a behavioural model.
module tb_sap_sequencer;

  localparam int PCW    = 4;
  localparam int PC_MOD = 16;
  localparam int STEPS  = 8;
  localparam int DEPTH  = 2;
  localparam int SW     = $clog2(STEPS);
  localparam int LW     = $clog2(DEPTH + 1);

  bit clk = 1'b0;
  bit rst_n = 1'b0;
  logic clk_en = 1'b1;
  logic ce = 1'b0, jmp = 1'b0, zf = 1'b0, cf = 1'b0, of = 1'b0;
  logic call = 1'b0, ret = 1'b0, adv = 1'b0, hlt = 1'b0, res = 1'b0;
  logic [1:0] cond = 2'd0;
  logic [PCW-1:0] data = '0;

  logic [PCW-1:0] o_pc;
  logic [SW-1:0]  o_step;
  logic           o_halted, o_fault;
  logic [LW-1:0]  o_stack_level;

  int checks = 0;
  int errors = 0;

  int m_pc = 0, m_step = 0, m_lvl = 0;
  bit m_halt = 1'b0, m_fault = 1'b0;
`ifdef SAP_SEQ_STACK_EN
  int m_stk [DEPTH];
`endif

  sap_sequencer #(.PC_WIDTH(PCW), .STEPS(STEPS), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .i_counter_enable(ce), .i_jump(jmp), .i_jump_cond(cond),
    .i_zero(zf), .i_carry(cf), .i_odd(of),
    .i_call(call), .i_ret(ret), .i_load_data(data),
    .i_adv(adv), .i_halt(hlt), .i_resume(res),
    .o_pc(o_pc), .o_step(o_step), .o_halted(o_halted),
    .o_fault(o_fault), .o_stack_level(o_stack_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_true(input logic [1:0] c, input logic z, input logic cy, input logic od);
    case (c)
      2'd0:    return 1'b1;
      2'd1:    return z;
      2'd2:    return cy;
      default: return od;
    endcase
  endfunction

  // Reference model: the sequencer's rules applied directly to integers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_step <= 0; m_lvl <= 0; m_halt <= 1'b0; m_fault <= 1'b0;
    end else if (clk_en && !m_fault) begin
      if (m_halt) begin
        if (res) begin
          m_halt <= 1'b0;
          m_step <= 0;
        end
      end else if (hlt) begin
        m_halt <= 1'b1;
      end
`ifdef SAP_SEQ_STACK_EN
      else if (ret && m_lvl == 0) m_fault <= 1'b1;
      else if (call && m_lvl == DEPTH) m_fault <= 1'b1;
`endif
      else begin
        m_step <= (adv || m_step == STEPS - 1) ? 0 : m_step + 1;
`ifdef SAP_SEQ_STACK_EN
        if (ret) begin
          m_pc  <= m_stk[m_lvl - 1];
          m_lvl <= m_lvl - 1;
        end else if (call) begin
          m_stk[m_lvl] <= (m_pc + 1) % PC_MOD;
          m_pc  <= int'(data);
          m_lvl <= m_lvl + 1;
        end else
`else
        if (call) m_pc <= int'(data); else
`endif
        if (jmp && cond_true(cond, zf, cf, of)) m_pc <= int'(data);
        else if (ce) m_pc <= (m_pc + 1) % PC_MOD;
      end
    end
  end

  // Compare every cycle, on the edge opposite the one that updates state.
  always @(negedge clk) begin
    chk("pc", int'(o_pc), m_pc);
    chk("step", int'(o_step), m_step);
    chk("halted", int'(o_halted), int'(m_halt));
    chk("fault", int'(o_fault), int'(m_fault));
    chk("level", int'(o_stack_level), m_lvl);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    clk_en = 1'b1; ce = 1'b0; jmp = 1'b0; cond = 2'd0; call = 1'b0; ret = 1'b0;
    adv = 1'b0; hlt = 1'b0; res = 1'b0; data = '0;
  endtask

  task automatic rand_reqs();
    ce   = 1'($urandom_range(0, 1));
    jmp  = ($urandom_range(0, 3) == 0);
    cond = 2'($urandom_range(0, 3));
    zf   = 1'($urandom_range(0, 1));
    cf   = 1'($urandom_range(0, 1));
    of   = 1'($urandom_range(0, 1));
    call = ($urandom_range(0, 7) == 0);
    ret  = ($urandom_range(0, 7) == 0);
    adv  = ($urandom_range(0, 5) == 0);
    data = PCW'($urandom_range(0, PC_MOD - 1));
  endtask

  int exp_pc;

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_pc", int'(o_pc), 0);
    chk("reset_step", int'(o_step), 0);
    chk("reset_level", int'(o_stack_level), 0);
    rst_n = 1'b1;

    // Five-step instruction: CE at step 1, end of instruction at step 4.
    for (int s = 0; s < 5; s++) begin
      ce = (s == 1); adv = (s == 4);
      tick();
    end
    idle();
    chk("instr_pc", int'(o_pc), 1);
    chk("instr_step", int'(o_step), 0);

    jmp = 1'b1; cond = 2'd1; zf = 1'b0; data = 4'd9; ce = 1'b1;
    tick();
    chk("jz_not_taken", int'(o_pc), 2);
    zf = 1'b1;
    tick();
    chk("jz_taken", int'(o_pc), 9);
    idle();

    jmp = 1'b1; data = 4'd3;
    tick();
    idle();
    chk("jmp_3", int'(o_pc), 3);
    call = 1'b1; data = 4'd12;
    tick();
    idle();
    chk("call_pc", int'(o_pc), 12);
    ret = 1'b1;
    tick();
    idle();
`ifdef SAP_SEQ_STACK_EN
    exp_pc = 4;
`else
    exp_pc = 12;
`endif
    chk("ret_pc", int'(o_pc), exp_pc);
    chk("ret_level", int'(o_stack_level), 0);

    // Halt at step 2, then hammer it with requests that must be ignored.
    adv = 1'b1; tick(); idle();
    tick(); tick();
    chk("pre_halt_step", int'(o_step), 2);
    hlt = 1'b1;
    tick();
    chk("halted", int'(o_halted), 1);
    for (int i = 0; i < 10; i++) begin
      rand_reqs();
      hlt = 1'($urandom_range(0, 1));
      tick();
      chk("halt_pc_frozen", int'(o_pc), exp_pc);
      chk("halt_step_frozen", int'(o_step), 2);
    end
    idle();
    res = 1'b1;
    tick();
    idle();
    chk("resume_halted", int'(o_halted), 0);
    chk("resume_step", int'(o_step), 0);
    chk("resume_pc", int'(o_pc), exp_pc);

    jmp = 1'b1; data = 4'd15; tick(); idle();
    ce = 1'b1; tick(); idle();
    chk("wrap_pc", int'(o_pc), 0);
    for (int i = 0; i < 3; i++) begin
      rand_reqs();
      hlt = 1'b1;
      clk_en = 1'b0;
      tick();
      chk("gated_pc", int'(o_pc), 0);
      chk("gated_step", int'(o_step), 2);
      chk("gated_halted", int'(o_halted), 0);
    end
    idle();

`ifdef SAP_SEQ_STACK_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      call = 1'b1; data = PCW'(5 + i);
      tick();
    end
    idle();
    chk("ovf_fault", int'(o_fault), 1);
    chk("ovf_level", int'(o_stack_level), 2);
    chk("ovf_pc", int'(o_pc), 6);
    rand_reqs(); res = 1'b1; tick(); idle();
    chk("fault_sticky_pc", int'(o_pc), 6);
    rst_n = 1'b0;
    #1;
    chk("rst_fault", int'(o_fault), 0);
    chk("rst_pc", int'(o_pc), 0);
    chk("rst_level", int'(o_stack_level), 0);
    tick();
    rst_n = 1'b1;
`endif

    for (int i = 0; i < 3000; i++) begin
      rand_reqs();
      clk_en = ($urandom_range(0, 7) != 0);
      hlt    = ($urandom_range(0, 19) == 0);
      res    = ($urandom_range(0, 3) == 0);
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
